bf16_acc_sequencer: RTL
=======================

# bf16_acc_sequencer

Parametrised command sequencer for the SPI bfloat16 coprocessor. It takes 16-bit words from the SPI slave, frames each word into a command with 0–2 operands, and owns a bank of `NUM_ACC` accumulators. Arithmetic is issued to one shared external FP unit through a request/response handshake. Results go back to the SPI slave as a single reply word. New over the previous generation: operand framing, multiple accumulators, two-step MAC/MAS, FPU timeout, and sticky status.

## Interface
Parameters:
- `WIDTH`, 16: data word width (bfloat16).
- `NUM_ACC`, 4: number of accumulators; power of two, 1–16.
- `TIMEOUT`, 255: maximum cycles to wait for the FPU result; 8-bit counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  WIDTH  word from the SPI slave.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` is valid.
- `tx_data`  out  WIDTH  reply word to the SPI slave.
- `tx_valid`  out  1  one-cycle pulse; `tx_data` is valid.
- `fpu_op`  out  2  operation: 0 ADD, 1 SUB (a−b), 2 MUL, 3 DIV (a/b).
- `fpu_a`, `fpu_b`  out  WIDTH  FPU operands.
- `fpu_req`  out  1  request; held until `fpu_ack`.
- `fpu_ack`  in  1  FPU accepted the request.
- `fpu_res`  in  WIDTH  FPU result.
- `fpu_res_valid`  in  1  one-cycle result pulse.
- `busy`  out  1  high in every state except IDLE.
- `status`  out  3  sticky bits: [0] illegal opcode, [1] overrun, [2] FPU timeout.

## Operation
- **Command word:**
  - `[3:0]` opcode.
  - `[7:4]` accumulator index. Only the low log2(`NUM_ACC`) bits are used.
  - Remaining bits are ignored.
- **Opcodes** (A, B are operand words that follow the command):
  - 0 ZERO: acc ← 0.
  - 1 SET: acc ← A.
  - 2 LOAD: reply acc.
  - 3 ADD2: reply A+B.
  - 4 SUB2: reply A−B.
  - 5 MPY2: reply A*B.
  - 6 DIV2: reply A/B.
  - 7 SUM: acc ← acc+A.
  - 8 SUB: acc ← acc−A.
  - 9 MAC: acc ← acc + A*B.
  - 10 MAS: acc ← acc − A*B.
  - 15 CLRST: status ← 0.
  - 11–14 illegal: set status[0], return to IDLE, no reply.
- **States:** IDLE, GET_A, GET_B, ISSUE, WAIT, ISSUE2, WAIT2, REPLY.
  - IDLE → GET_A on a command needing operands; otherwise execute directly.
  - GET_A → GET_B (2-operand commands) or ISSUE.
  - GET_B → ISSUE.
  - ISSUE → WAIT on `fpu_ack`.
  - WAIT → ISSUE2 only for MAC/MAS when the product arrives.
  - ISSUE2 → WAIT2 on `fpu_ack`.
  - WAIT/WAIT2 → REPLY (reply opcodes) or IDLE (accumulator write).
  - REPLY → IDLE.
- **MAC/MAS:** step 1 is MUL(A,B). Step 2 is ADD(acc, product) or SUB(acc, product), using the accumulator value sampled at step 2.
- **Overrun:** `rx_valid` arriving in ISSUE, WAIT, ISSUE2, WAIT2 or REPLY is dropped and sets status[1]. Operand states consume `rx_valid` normally.
- **Timeout:** the counter resets on entry to WAIT/WAIT2. If it reaches `TIMEOUT` without `fpu_res_valid`:
  - set status[2];
  - leave the accumulator unchanged;
  - send no reply;
  - go to IDLE.
- **Stray results:** `fpu_res_valid` outside WAIT/WAIT2 is ignored.
- **FP semantics:** no FP arithmetic is done in this block; ZERO writes 0x0000.

## Timing
- **Reset values:** all accumulators 0, `tx_data` 0, `tx_valid` 0, `fpu_req` 0, `fpu_op` 0, `fpu_a`/`fpu_b` 0, `busy` 0, `status` 0, state IDLE.
- ZERO, SET (on the cycle after A) and CLRST take effect on the clock edge after the relevant `rx_valid`. `busy` stays low for ZERO and CLRST.
- LOAD: `tx_valid` pulses one cycle after the command's `rx_valid`.
- `fpu_req` rises on the cycle after the last operand. `fpu_a`, `fpu_b` and `fpu_op` are stable while `fpu_req` is high.
- Reply opcodes: `tx_valid` pulses one cycle after `fpu_res_valid`.
- Accumulator opcodes: the accumulator updates on the edge of `fpu_res_valid`; `busy` falls the next cycle.
- `fpu_ack` and `fpu_res_valid` in the same cycle: the result is accepted.
- A new command is accepted in the first IDLE cycle.
- Reset mid-operation: the outstanding request is abandoned and `fpu_req` drops immediately.

## Structure
- Shared package `bf16_acc_pkg`:
  - opcode constants;
  - FPU op encodings;
  - status bit indices;
  - BF16 constants `BF16_ZERO`, `BF16_ONE` (0x3F80).
- One sub-module, `bf16_acc_regfile`: `NUM_ACC`×`WIDTH` registers, one synchronous write port, one combinational read port, async reset to 0.

## Test plan
- SET acc1 ← 0x3F80, then LOAD acc1 → `tx_data` 0x3F80 one cycle after the LOAD `rx_valid`; acc0 still reads 0x0000.
- ADD2 0x3F80, 0x4000; model FPU returns 0x4040 after 3 cycles → `fpu_op`=0, then `tx_valid` with 0x4040. `busy` is high from the first operand to the reply.
- MAC acc2 (preset 0x3F80) with A=0x4000, B=0x4000 → first request MUL(0x4000,0x4000), then ADD(0x3F80,0x4080); acc2 becomes 0x40A0 and no reply is sent.
- FPU never responds to MPY2 → status[2] is set after `TIMEOUT` cycles, no `tx_valid`, back to IDLE; a following LOAD works.
- Opcode 12 → status=001, no reply. A command sent during WAIT → status[1] is set and the in-flight result is unaffected. CLRST → status=000.
- Assert `rst` while in WAIT with `fpu_req` high → all outputs at reset values on the same cycle.

Source files
------------

// File: rtl/bf16_acc_pkg.sv
// Shared definitions for the bfloat16 accumulator sequencer.
// Holds the command opcodes, the FPU operation encodings, the status bit
// positions, the bfloat16 constants, the sequencer state type and small
// decode helpers used by the sequencer.
package bf16_acc_pkg;

    // Command opcodes (command word bits [3:0])
    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_SET   = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD2  = 4'd3;
    localparam logic [3:0] OP_SUB2  = 4'd4;
    localparam logic [3:0] OP_MPY2  = 4'd5;
    localparam logic [3:0] OP_DIV2  = 4'd6;
    localparam logic [3:0] OP_SUM   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_MAC   = 4'd9;
    localparam logic [3:0] OP_MAS   = 4'd10;
    localparam logic [3:0] OP_CLRST = 4'd15;

    // FPU operation encodings
    localparam logic [1:0] FPU_ADD = 2'd0;
    localparam logic [1:0] FPU_SUB = 2'd1;
    localparam logic [1:0] FPU_MUL = 2'd2;
    localparam logic [1:0] FPU_DIV = 2'd3;

    // Sticky status bit positions
    localparam int unsigned ST_ILLEGAL = 0;
    localparam int unsigned ST_OVERRUN = 1;
    localparam int unsigned ST_TIMEOUT = 2;

    // bfloat16 constants
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StIssue,
        StWait,
        StIssue2,
        StWait2,
        StReply
    } state_e;

    // Number of operand words that follow a command word.
    function automatic logic [1:0] operand_count(input logic [3:0] op);
        case (op)
            OP_SET, OP_SUM, OP_SUB:                   return 2'd1;
            OP_ADD2, OP_SUB2, OP_MPY2, OP_DIV2,
            OP_MAC, OP_MAS:                           return 2'd2;
            default:                                  return 2'd0;
        endcase
    endfunction

    // Commands whose FPU result is returned to the host instead of stored.
    function automatic logic is_reply_op(input logic [3:0] op);
        return (op == OP_ADD2) || (op == OP_SUB2) || (op == OP_MPY2) || (op == OP_DIV2);
    endfunction

    // FPU operation for the first (or only) request of a command.
    function automatic logic [1:0] fpu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB2, OP_SUB:          return FPU_SUB;
            OP_MPY2, OP_MAC, OP_MAS:  return FPU_MUL;
            OP_DIV2:                  return FPU_DIV;
            default:                  return FPU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bf16_acc_regfile.sv
// Accumulator bank for the bfloat16 sequencer.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (clears all entries)
//   wr_en/idx/data   synchronous write port
//   rd_idx, rd_data  combinational read port
module bf16_acc_regfile
    import bf16_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned AW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [NUM_ACC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ACC); i++) begin
                mem_q[i] <= WIDTH'(BF16_ZERO);
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/bf16_acc_sequencer.sv
// Command sequencer for the SPI bfloat16 coprocessor.
// Frames SPI words into commands with 0-2 operands, owns NUM_ACC accumulators
// and drives one shared FPU through a req/ack + result-pulse handshake.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rx_data, rx_valid             words from the SPI slave
//   tx_data, tx_valid             single-word reply to the SPI slave
//   fpu_op, fpu_a, fpu_b, fpu_req FPU request (held until fpu_ack)
//   fpu_ack, fpu_res, fpu_res_valid FPU acceptance and result pulse
//   busy                          high whenever not idle
//   status                        sticky {timeout, overrun, illegal opcode}
module bf16_acc_sequencer
    import bf16_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic [1:0]       fpu_op,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic             fpu_req,
    input  logic             fpu_ack,
    input  logic [WIDTH-1:0] fpu_res,
    input  logic             fpu_res_valid,
    output logic             busy,
    output logic [2:0]       status
);

    localparam int unsigned   AW       = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [AW-1:0] IDX_MASK = AW'(NUM_ACC - 1);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             fpu_req_q, fpu_req_d;
    logic [1:0]       fpu_op_q, fpu_op_d;
    logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
    logic [WIDTH-1:0] fpu_b_q, fpu_b_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;

    logic [3:0]       rx_op;
    logic [AW-1:0]    rx_idx;
    logic             take1, take2;

    assign rx_op  = rx_data[3:0];
    assign rx_idx = rx_data[4 +: AW] & IDX_MASK;

    bf16_acc_regfile #(
        .WIDTH   (WIDTH),
        .NUM_ACC (NUM_ACC),
        .AW      (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        a_d        = a_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        fpu_req_d  = fpu_req_q;
        fpu_op_d   = fpu_op_q;
        fpu_a_d    = fpu_a_q;
        fpu_b_d    = fpu_b_q;
        wr_en      = 1'b0;
        wr_idx     = idx_q;
        wr_data    = fpu_res;
        rd_idx     = idx_q;

        // A result counts when waiting, or when it coincides with the ack.
        take1 = fpu_res_valid && ((state_q == StWait) || (state_q == StIssue && fpu_ack));
        take2 = fpu_res_valid && ((state_q == StWait2) || (state_q == StIssue2 && fpu_ack));

        if (rx_valid && (state_q inside {StIssue, StWait, StIssue2, StWait2, StReply})) begin
            status_d[ST_OVERRUN] = 1'b1;
        end

        case (state_q)
            StIdle: begin
                rd_idx = rx_idx;
                if (rx_valid) begin
                    op_d  = rx_op;
                    idx_d = rx_idx;
                    case (rx_op)
                        OP_ZERO: begin
                            wr_en   = 1'b1;
                            wr_idx  = rx_idx;
                            wr_data = WIDTH'(BF16_ZERO);
                        end
                        OP_LOAD: begin
                            tx_data_d  = rd_data;
                            tx_valid_d = 1'b1;
                            state_d    = StReply;
                        end
                        OP_CLRST: status_d = '0;
                        OP_SET, OP_ADD2, OP_SUB2, OP_MPY2, OP_DIV2,
                        OP_SUM, OP_SUB, OP_MAC, OP_MAS: state_d = StGetA;
                        default: status_d[ST_ILLEGAL] = 1'b1;
                    endcase
                end
            end
            StGetA: begin
                if (rx_valid) begin
                    a_d = rx_data;
                    if (op_q == OP_SET) begin
                        wr_en   = 1'b1;
                        wr_data = rx_data;
                        state_d = StIdle;
                    end else if (operand_count(op_q) == 2'd2) begin
                        state_d = StGetB;
                    end else begin
                        // SUM/SUB: accumulator is the left operand
                        fpu_op_d  = fpu_op_of(op_q);
                        fpu_a_d   = rd_data;
                        fpu_b_d   = rx_data;
                        fpu_req_d = 1'b1;
                        state_d   = StIssue;
                    end
                end
            end
            StGetB: begin
                if (rx_valid) begin
                    fpu_op_d  = fpu_op_of(op_q);
                    fpu_a_d   = a_q;
                    fpu_b_d   = rx_data;
                    fpu_req_d = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue, StIssue2: begin
                if (fpu_ack) begin
                    fpu_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = (state_q == StIssue) ? StWait : StWait2;
                end
            end
            StWait, StWait2: begin
                if (!fpu_res_valid) begin
                    if (cnt_q == TMO_LAST) begin
                        status_d[ST_TIMEOUT] = 1'b1;
                        state_d              = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StReply: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (take1) begin
            if (op_q == OP_MAC || op_q == OP_MAS) begin
                // Second step combines the product with the current accumulator.
                fpu_op_d  = (op_q == OP_MAS) ? FPU_SUB : FPU_ADD;
                fpu_a_d   = rd_data;
                fpu_b_d   = fpu_res;
                fpu_req_d = 1'b1;
                state_d   = StIssue2;
            end else if (is_reply_op(op_q)) begin
                tx_data_d  = fpu_res;
                tx_valid_d = 1'b1;
                state_d    = StReply;
            end else begin
                wr_en   = 1'b1;
                state_d = StIdle;
            end
        end

        if (take2) begin
            wr_en   = 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            fpu_req_q  <= 1'b0;
            fpu_op_q   <= '0;
            fpu_a_q    <= '0;
            fpu_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            fpu_req_q  <= fpu_req_d;
            fpu_op_q   <= fpu_op_d;
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign fpu_req  = fpu_req_q;
    assign fpu_op   = fpu_op_q;
    assign fpu_a    = fpu_a_q;
    assign fpu_b    = fpu_b_q;
    assign status   = status_q;
    assign busy     = (state_q != StIdle);

endmodule
